// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - handshake and bus bundle between decoder/bench, target LUT and pc_fetch_ctrl
//
// Signals (directions seen from the controller, modport slave):
//   Init          in   one-cycle start pulse
//   Branch_taken  in   taken branch or jump this cycle
//   Branch_ptr    in   LUT pointer from the current instruction
//   Halt          in   program-done instruction seen
//   PC_target     in   combinational return from the target LUT
//   LUT_addr      out  pointer to the LUT (pass of Branch_ptr)
//   Prog_state    out  active program index 0..2
//   PC            out  instruction-memory address
//   Running       out  high while a program runs
//   Ack           out  high once a program has finished
//   Cycle_count   out  RUN cycle counter, present only with PC_CYCLE_COUNT_EN
// The master modport is the driving side (decoder, LUT, bench).
interface pc_fetch_ctrl_if #(
    parameter int PC_W  = 10,
    parameter int PTR_W = 3
);
    logic             Init;
    logic             Branch_taken;
    logic [PTR_W-1:0] Branch_ptr;
    logic             Halt;
    logic [PC_W-1:0]  PC_target;
    logic [PTR_W-1:0] LUT_addr;
    logic [1:0]       Prog_state;
    logic [PC_W-1:0]  PC;
    logic             Running;
    logic             Ack;
`ifdef PC_CYCLE_COUNT_EN
    logic [15:0]      Cycle_count;
`endif

    modport master (
        output Init, Branch_taken, Branch_ptr, Halt, PC_target,
        input  LUT_addr, Prog_state, PC, Running, Ack
`ifdef PC_CYCLE_COUNT_EN
        , input Cycle_count
`endif
    );

    modport slave (
        input  Init, Branch_taken, Branch_ptr, Halt, PC_target,
        output LUT_addr, Prog_state, PC, Running, Ack
`ifdef PC_CYCLE_COUNT_EN
        , output Cycle_count
`endif
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and three-program sequencer driving the branch-target LUT
//
// Ports:
//   Clk      in   sole clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   bus      pc_fetch_ctrl_if.slave (Init/Branch/Halt/PC_target in; LUT_addr,
//            Prog_state, PC, Running, Ack out; Cycle_count out when enabled)
// Optional feature macro: PC_CYCLE_COUNT_EN adds a saturating 16-bit count of
// RUN cycles on bus.Cycle_count, cleared on reset and on each accepted Init.
module pc_fetch_ctrl #(
    parameter int PC_W   = 10,
    parameter int PTR_W  = 3,
    parameter int START0 = 0,
    parameter int START1 = 0,
    parameter int START2 = 0
) (
    input  logic           Clk,
    input  logic           Reset_n,
    pc_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [1:0]       prog_q, prog_d;
    logic             first_run_q, first_run_d;
    logic             init_accept;
    logic [PTR_W-1:0] lut_addr;

    function automatic logic [PC_W-1:0] start_of(input logic [1:0] p);
        case (p)
            2'd1:    return PC_W'(START1);
            2'd2:    return PC_W'(START2);
            default: return PC_W'(START0);
        endcase
    endfunction

    // Program index cycles 0->1->2->0 so the value 3 is never produced.
    function automatic logic [1:0] next_prog(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Init is only honoured outside RUN; a mid-program Init is dropped.
    assign init_accept = bus.Init && (state_q != RUN);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            prog_q      <= 2'd0;
            first_run_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            prog_q      <= prog_d;
            first_run_q <= first_run_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        prog_d      = prog_q;
        first_run_d = first_run_q;
        case (state_q)
            RUN: begin
                // Halt outranks a branch in the same cycle and freezes PC.
                if (bus.Halt) begin
                    state_d = DONE;
                end else if (bus.Branch_taken) begin
                    pc_d = bus.PC_target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            IDLE, DONE: begin
                if (init_accept) begin
                    state_d     = RUN;
                    first_run_d = 1'b0;
                    // The first start after reset runs the current program;
                    // every later start moves on to the next one.
                    prog_d      = first_run_q ? prog_q : next_prog(prog_q);
                    pc_d        = start_of(prog_d);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PC_CYCLE_COUNT_EN
    logic [15:0] cycle_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cycle_q <= '0;
        end else if (init_accept) begin
            cycle_q <= '0;
        end else if ((state_q == RUN) && (cycle_q != 16'hFFFF)) begin
            cycle_q <= cycle_q + 16'd1;
        end
    end

    assign bus.Cycle_count = cycle_q;
`endif

    assign lut_addr       = bus.Branch_ptr;
    assign bus.LUT_addr   = lut_addr;
    assign bus.PC         = pc_q;
    assign bus.Prog_state = prog_q;
    assign bus.Running    = (state_q == RUN);
    assign bus.Ack        = (state_q == DONE);
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
    logic Clk;
    logic Reset_n;
    int   errors;
    int   checks;

    pc_fetch_ctrl_if #(.PC_W(10), .PTR_W(3)) bus ();
    pc_fetch_ctrl_if #(.PC_W(10), .PTR_W(3)) bus_w ();

    pc_fetch_ctrl #(.PC_W(10), .PTR_W(3), .START0(0), .START1(100), .START2(40)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    pc_fetch_ctrl #(.PC_W(10), .PTR_W(3), .START0(1022), .START1(0), .START2(0)) dut_w (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_w)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Target LUT model indexed by {Prog_state, LUT_addr}.
    function automatic logic [9:0] lut(input logic [1:0] p, input logic [2:0] a);
        if (p == 2'd1 && a == 3'd5) return 10'd300;
        if (a == 3'd2)              return 10'd77;
        if (a == 3'd4)              return 10'd12;
        return 10'd500 + 10'({p, a});
    endfunction

    always_comb bus.PC_target   = lut(bus.Prog_state, bus.LUT_addr);
    always_comb bus_w.PC_target = lut(bus_w.Prog_state, bus_w.LUT_addr);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        bus.Init = 0; bus.Branch_taken = 0; bus.Halt = 0; bus.Branch_ptr = 3'd3;
        bus_w.Init = 0; bus_w.Branch_taken = 0; bus_w.Halt = 0; bus_w.Branch_ptr = 3'd0;
        step(); step();
        checks++; if (bus.PC !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", bus.PC); end
        checks++; if (bus.Prog_state !== 2'd0) begin errors++; $display("FAIL reset_prog: got %0d expected 0", bus.Prog_state); end
        checks++; if (bus.Running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", bus.Running); end
        checks++; if (bus.Ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.Ack); end
        checks++; if (bus.LUT_addr !== 3'd3) begin errors++; $display("FAIL reset_lut_addr: got %0d expected 3", bus.LUT_addr); end
        checks++; if (bus_w.PC !== 10'd0) begin errors++; $display("FAIL reset_pc_w: got %0d expected 0", bus_w.PC); end
`ifdef PC_CYCLE_COUNT_EN
        checks++; if (bus.Cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.Cycle_count); end
`endif
        Reset_n = 1'b1;
        // Branch and Halt are ignored in IDLE.
        bus.Branch_taken = 1; bus.Halt = 1; bus.Branch_ptr = 3'd5;
        step();
        bus.Branch_taken = 0; bus.Halt = 0;
        checks++; if (bus.PC !== 10'd0) begin errors++; $display("FAIL idle_pc_hold: got %0d expected 0", bus.PC); end
        checks++; if (bus.Ack !== 1'b0 || bus.Running !== 1'b0) begin errors++; $display("FAIL idle_ignore: got ack=%b run=%b expected 0 0", bus.Ack, bus.Running); end
    endtask

    task automatic test_wrap();
        bus_w.Init = 1; step(); bus_w.Init = 0;
        checks++; if (bus_w.PC !== 10'd1022) begin errors++; $display("FAIL wrap_start: got %0d expected 1022", bus_w.PC); end
        step();
        checks++; if (bus_w.PC !== 10'd1023) begin errors++; $display("FAIL wrap_1023: got %0d expected 1023", bus_w.PC); end
        step();
        checks++; if (bus_w.PC !== 10'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", bus_w.PC); end
        step();
        checks++; if (bus_w.PC !== 10'd1) begin errors++; $display("FAIL wrap_1: got %0d expected 1", bus_w.PC); end
        bus_w.Halt = 1; step(); bus_w.Halt = 0;
        checks++; if (bus_w.Ack !== 1'b1 || bus_w.PC !== 10'd1) begin errors++; $display("FAIL wrap_halt: got ack=%b pc=%0d expected 1 1", bus_w.Ack, bus_w.PC); end
    endtask

    task automatic test_init_increment();
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Running !== 1'b1) begin errors++; $display("FAIL init_running: got %b expected 1", bus.Running); end
        checks++; if (bus.PC !== 10'd0 || bus.Prog_state !== 2'd0) begin errors++; $display("FAIL init_pc_prog: got pc=%0d prog=%0d expected 0 0", bus.PC, bus.Prog_state); end
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++; if (bus.PC !== 10'(i)) begin errors++; $display("FAIL incr_pc: got %0d expected %0d", bus.PC, i); end
        end
        // Init during RUN is dropped.
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.PC !== 10'd6 || bus.Prog_state !== 2'd0 || bus.Running !== 1'b1) begin
            errors++; $display("FAIL run_init_ignored: got pc=%0d prog=%0d run=%b expected 6 0 1", bus.PC, bus.Prog_state, bus.Running);
        end
    endtask

    task automatic test_halt();
        bus.Halt = 1; step(); bus.Halt = 0;
        checks++; if (bus.Ack !== 1'b1 || bus.Running !== 1'b0) begin errors++; $display("FAIL halt_ack: got ack=%b run=%b expected 1 0", bus.Ack, bus.Running); end
        checks++; if (bus.PC !== 10'd6) begin errors++; $display("FAIL halt_pc_hold: got %0d expected 6", bus.PC); end
        bus.Branch_taken = 1; bus.Branch_ptr = 3'd5; bus.Halt = 1; step();
        bus.Branch_taken = 0; bus.Halt = 0;
        checks++; if (bus.PC !== 10'd6 || bus.Ack !== 1'b1) begin errors++; $display("FAIL done_ignore: got pc=%0d ack=%b expected 6 1", bus.PC, bus.Ack); end
    endtask

    task automatic test_branch_prog1();
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Prog_state !== 2'd1 || bus.PC !== 10'd100) begin errors++; $display("FAIL prog1_start: got prog=%0d pc=%0d expected 1 100", bus.Prog_state, bus.PC); end
        checks++; if (bus.Ack !== 1'b0 || bus.Running !== 1'b1) begin errors++; $display("FAIL prog1_ack_drop: got ack=%b run=%b expected 0 1", bus.Ack, bus.Running); end
        bus.Branch_taken = 1; bus.Branch_ptr = 3'd5; #1;
        checks++; if (bus.LUT_addr !== 3'd5) begin errors++; $display("FAIL lut_addr: got %0d expected 5", bus.LUT_addr); end
        step(); bus.Branch_taken = 0;
        checks++; if (bus.PC !== 10'd300) begin errors++; $display("FAIL branch_pc: got %0d expected 300", bus.PC); end
        step();
        checks++; if (bus.PC !== 10'd301) begin errors++; $display("FAIL branch_then_incr: got %0d expected 301", bus.PC); end
        bus.Halt = 1; step(); bus.Halt = 0;
    endtask

    task automatic test_simultaneous();
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Prog_state !== 2'd2 || bus.PC !== 10'd40) begin errors++; $display("FAIL prog2_start: got prog=%0d pc=%0d expected 2 40", bus.Prog_state, bus.PC); end
        bus.Branch_taken = 1; bus.Branch_ptr = 3'd4; step(); bus.Branch_taken = 0;
        checks++; if (bus.PC !== 10'd12) begin errors++; $display("FAIL branch_to_12: got %0d expected 12", bus.PC); end
        bus.Halt = 1; bus.Branch_taken = 1; bus.Branch_ptr = 3'd2; step();
        bus.Halt = 0; bus.Branch_taken = 0;
        checks++; if (bus.PC !== 10'd12 || bus.Ack !== 1'b1 || bus.Running !== 1'b0) begin
            errors++; $display("FAIL halt_beats_branch: got pc=%0d ack=%b run=%b expected 12 1 0", bus.PC, bus.Ack, bus.Running);
        end
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Prog_state !== 2'd0 || bus.PC !== 10'd0) begin errors++; $display("FAIL prog_wrap_0: got prog=%0d pc=%0d expected 0 0", bus.Prog_state, bus.PC); end
        bus.Init = 1; bus.Halt = 1; step(); bus.Init = 0; bus.Halt = 0;
        checks++; if (bus.Ack !== 1'b1 || bus.Prog_state !== 2'd0 || bus.PC !== 10'd0) begin
            errors++; $display("FAIL init_halt_run: got ack=%b prog=%0d pc=%0d expected 1 0 0", bus.Ack, bus.Prog_state, bus.PC);
        end
        step();
        checks++; if (bus.Ack !== 1'b1 || bus.Running !== 1'b0) begin errors++; $display("FAIL init_dropped: got ack=%b run=%b expected 1 0", bus.Ack, bus.Running); end
    endtask

    task automatic test_reset_mid_run();
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Prog_state !== 2'd1) begin errors++; $display("FAIL round_prog1: got %0d expected 1", bus.Prog_state); end
        bus.Halt = 1; step(); bus.Halt = 0;
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Prog_state !== 2'd2 || bus.PC !== 10'd40 || bus.Running !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got prog=%0d pc=%0d run=%b expected 2 40 1", bus.Prog_state, bus.PC, bus.Running);
        end
        Reset_n = 1'b0; #1;
        checks++; if (bus.PC !== 10'd0 || bus.Prog_state !== 2'd0) begin errors++; $display("FAIL async_reset_pc_prog: got pc=%0d prog=%0d expected 0 0", bus.PC, bus.Prog_state); end
        checks++; if (bus.Running !== 1'b0 || bus.Ack !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got run=%b ack=%b expected 0 0", bus.Running, bus.Ack); end
        step(); Reset_n = 1'b1;
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Prog_state !== 2'd0 || bus.PC !== 10'd0 || bus.Running !== 1'b1) begin
            errors++; $display("FAIL post_reset_init: got prog=%0d pc=%0d run=%b expected 0 0 1", bus.Prog_state, bus.PC, bus.Running);
        end
        bus.Halt = 1; step(); bus.Halt = 0;
    endtask

`ifdef PC_CYCLE_COUNT_EN
    task automatic test_cycle_count();
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Cycle_count !== 16'd0) begin errors++; $display("FAIL count_clear: got %0d expected 0", bus.Cycle_count); end
        repeat (7) step();
        bus.Halt = 1; step(); bus.Halt = 0;
        checks++; if (bus.Cycle_count !== 16'd8 || bus.Ack !== 1'b1) begin errors++; $display("FAIL count_8: got %0d ack=%b expected 8 1", bus.Cycle_count, bus.Ack); end
        step();
        checks++; if (bus.Cycle_count !== 16'd8) begin errors++; $display("FAIL count_hold: got %0d expected 8", bus.Cycle_count); end
        bus.Init = 1; step(); bus.Init = 0;
        checks++; if (bus.Cycle_count !== 16'd0) begin errors++; $display("FAIL count_reclear: got %0d expected 0", bus.Cycle_count); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_wrap();
        test_init_increment();
        test_halt();
        test_branch_prog1();
        test_simultaneous();
        test_reset_mid_run();
`ifdef PC_CYCLE_COUNT_EN
        test_cycle_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program counter and program-sequencing controller that consumes the branch-target lookup table. Tracks which of three programs is active (`Prog_state`), drives the LUT pointer and program index to the target table, and loads the returned `PC_target` on taken branches and jumps, otherwise incrementing the PC. It also runs the Init/Ack handshake with the test bench. Sits between the instruction decoder and instruction memory.

## Interface
- `PC_W`, 10: PC and `PC_target` width.
- `PTR_W`, 3: LUT pointer width.
- `START0`, 0: program 0 start address.
- `START1`, 0: program 1 start address.
- `START2`, 0: program 2 start address.
- `Clk`  in  1: sole clock, rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Init`  in  1: one-cycle start pulse from bench.
- `Branch_taken`  in  1: decoder asserts a taken branch or jump this cycle.
- `Branch_ptr`  in  PTR_W: LUT pointer carried in the current instruction.
- `Halt`  in  1: decoder sees the program-done instruction.
- `PC_target`  in  PC_W: combinational return from the target LUT.
- `LUT_addr`  out  PTR_W: pointer to the LUT; equals `Branch_ptr`.
- `Prog_state`  out  2: active program index 0..2, registered.
- `PC`  out  PC_W: instruction-memory address, registered.
- `Running`  out  1: high in RUN.
- `Ack`  out  1: high in DONE.

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- Reset values: `PC`=0, `Prog_state`=0, `Running`=0, `Ack`=0, first-run flag=1.
- **IDLE + Init**
  - Go to RUN.
  - `Prog_state` is unchanged (program 0 after reset).
  - `PC` loads START[`Prog_state`].
  - Clear the first-run flag.
- **DONE + Init**
  - Go to RUN.
  - `Prog_state` advances 0→1→2→0; the value 3 never occurs.
  - `PC` loads START of the new `Prog_state`.
  - `Ack` drops.
- **RUN, next PC priority**
  - `Halt`: go to DONE and hold `PC`.
  - Else `Branch_taken`: `PC` loads `PC_target`.
  - Else `PC` is incremented modulo 2^PC_W; 1023 wraps to 0.
- **RUN + Init**: Init is ignored; there is no restart mid-program.
- **IDLE/DONE**: `Branch_taken` and `Halt` are ignored. `PC` holds.
- `LUT_addr` is a combinational pass of `Branch_ptr` and is valid in all states. The external LUT sees {`Prog_state`,`LUT_addr`}.
- `Prog_state` changes only on an accepted Init. It is constant throughout RUN.
- If `Reset_n` is asserted mid-RUN, all registers return to reset values immediately. The next Init runs program 0.

## Timing
- Init sampled at edge N → `Running`=1 and `PC`=START from edge N (visible in cycle N+1).
- Branch latency: `Branch_taken` in cycle N → `PC`=`PC_target` after edge N. This is a single-cycle combinational path from `Branch_ptr` through the LUT to the `PC` D-input.
- `Halt` in cycle N → `Ack`=1 and `Running`=0 after edge N. `Ack` stays high until the next accepted Init.
- If `Halt` and `Branch_taken` are asserted in the same cycle, `Halt` wins and `PC` is unchanged.
- If `Init` and `Halt` coincide in RUN, `Halt` is taken and `Init` is dropped.

## Configuration
- `PC_CYCLE_COUNT_EN` defined: adds output `Cycle_count` [15:0].
  - Cleared to 0 on an accepted Init and on reset.
  - Increments once per RUN cycle and saturates at 16'hFFFF.
  - Holds in DONE so the bench can read it alongside `Ack`.
- `PC_CYCLE_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset then Init** (START0=0): `PC`=0, `Prog_state`=0, `Running`=1. With 5 idle cycles, `PC` steps 1,2,3,4,5.
- **Branch in program 1**: LUT returns 10'd300 for {01,101}. Drive Init, Halt, Init to reach `Prog_state`=1, then `Branch_taken`=1 with ptr=5 → `LUT_addr`=5 and `PC`=300 next cycle.
- **Simultaneous events**: `Halt`+`Branch_taken` (ptr=2, target 77) at `PC`=12 → `PC` stays 12 and `Ack`=1. `Init`+`Halt` in RUN → DONE, and `Prog_state` is unchanged.
- **Wrap-around**: START0=1022 with 3 run cycles → `PC` goes 1022,1023,0,1. Three full Init/Halt rounds → `Prog_state` goes 0,1,2,0 and never 3.
- **Reset mid-run**: `Reset_n` low at `PC`=40, `Prog_state`=2 → same cycle `PC`=0, `Prog_state`=0, `Running`=0, `Ack`=0.
- **`PC_CYCLE_COUNT_EN` only**: Init, 7 RUN cycles, Halt → `Cycle_count`=8 and held. The next Init clears it to 0.
